branch_predict_ctrl: RTL and testbench

Branch prediction and resolution controller for the RV32IM five-stage pipeline. It looks up a direct-mapped branch target buffer (BTB) with 2-bit saturating counters to predict the next fetch PC in IF. It resolves conditional branches and JAL in EX using the RV32I funct3 compare rules. On a misprediction it issues the PC redirect and the IF/ID and ID/EX flush, then trains the BTB.

---
 rtl/branch_predict_ctrl.sv | 159 +++++++++++++++
 tb/tb_branch_predict_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_ctrl
// Description : Branch prediction and resolution controller for an RV32IM
//               five-stage pipeline. A direct-mapped BTB with 2-bit saturating
//               counters predicts the next fetch PC in IF. Conditional
//               branches and JAL are resolved in EX. On a misprediction the
//               block issues the PC redirect and the IF/ID + ID/EX flush, and
//               it trains the BTB.
// Ports       :
//   clk, reset                  clock, asynchronous active-high reset
//   if_pc                       PC being fetched
//   pred_taken / pred_target    combinational prediction for if_pc
//   ex_*                        EX-stage instruction and its operands
//   stall                       pipeline frozen this cycle
//   redirect / redirect_pc      PC correction (combinational)
//   flush                       squash IF/ID and ID/EX (combinational)
//   mispredict_count            saturating misprediction counter
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1_data,
  input  logic [31:0] ex_rs2_data,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  // BTB storage
  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [31:0]       r_target [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];
  logic [15:0]       r_mis_cnt;

  // IF lookup
  logic [IDX_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]    w_if_tag;
  logic                w_if_hit;
  logic                w_pred_taken;

  // EX resolution
  logic [IDX_BITS-1:0] w_ex_idx;
  logic [TAG_W-1:0]    w_ex_tag;
  logic                w_ex_hit;
  logic                w_cond_taken;
  logic                w_taken;
  logic                w_active;
  logic                w_mispredict;
  logic                w_unused_bits;

  // Byte-offset bits of word-aligned PCs never take part in index/tag.
  assign w_unused_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign w_if_idx = if_pc[IDX_BITS+1:2];
  assign w_if_tag = if_pc[31:IDX_BITS+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

  // Reset gating keeps the outputs quiet for the whole reset window,
  // independent of how quickly the storage clears.
  assign w_pred_taken = w_if_hit & r_ctr[w_if_idx][1] & ~reset;
  assign pred_taken   = w_pred_taken;
  assign pred_target  = w_pred_taken ? r_target[w_if_idx] : (if_pc + 32'd4);

  assign w_ex_idx = ex_pc[IDX_BITS+1:2];
  assign w_ex_tag = ex_pc[31:IDX_BITS+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  always_comb begin
    w_cond_taken = 1'b0;
    case (ex_funct3)
      3'b000:  w_cond_taken = (ex_rs1_data == ex_rs2_data);
      3'b001:  w_cond_taken = (ex_rs1_data != ex_rs2_data);
      3'b100:  w_cond_taken = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
      3'b101:  w_cond_taken = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
      3'b110:  w_cond_taken = (ex_rs1_data <  ex_rs2_data);
      3'b111:  w_cond_taken = (ex_rs1_data >= ex_rs2_data);
      default: w_cond_taken = 1'b0;
    endcase
  end

  assign w_taken  = ex_is_jal | (ex_is_branch & w_cond_taken);
  assign w_active = ex_valid & (ex_is_branch | ex_is_jal) & ~stall;

  // A taken branch is also mispredicted when the carried target is stale.
  assign w_mispredict = w_active & ~reset &
                        (w_taken ? (~ex_pred_taken | (ex_pred_target != ex_target))
                                 : ex_pred_taken);

  assign redirect    = w_mispredict;
  assign flush       = w_mispredict;
  assign redirect_pc = (w_mispredict & ~w_taken) ? (ex_pc + 32'd4) : ex_target;

  assign mispredict_count = r_mis_cnt;

  // BTB training
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (w_active) begin
      if (ex_is_jal) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= ex_target;
        r_ctr[w_ex_idx]    <= 2'b11;
      end else if (w_ex_hit) begin
        if (w_taken) begin
          r_target[w_ex_idx] <= ex_target;
          if (r_ctr[w_ex_idx] != 2'b11) begin
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
          end
        end else if (r_ctr[w_ex_idx] != 2'b00) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
        end
      end else if (w_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= ex_target;
        r_ctr[w_ex_idx]    <= 2'b10;
      end
    end
  end

  // Misprediction counter, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mis_cnt <= 16'h0000;
    end else if (w_mispredict && (r_mis_cnt != 16'hFFFF)) begin
      r_mis_cnt <= r_mis_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_ctrl
// Description : Scoreboard bench for branch_predict_ctrl. The driver computes
//               expected outputs from a behavioural BTB model and queues them;
//               a monitor compares them with the DUT on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_is_jal;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_pc, ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.IDX_BITS(4)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_funct3(ex_funct3), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .mispredict_count(mispredict_count)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    string       nm;
    logic        pt;
    logic [31:0] ptgt;
    logic        rd;
    logic [31:0] rpc;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.nm, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, e.pt});
        check({e.nm, ".pred_target"}, pred_target, e.ptgt);
        check({e.nm, ".redirect"},    {31'd0, redirect}, {31'd0, e.rd});
        check({e.nm, ".flush"},       {31'd0, flush},    {31'd0, e.rd});
        if (e.rd) check({e.nm, ".redirect_pc"}, redirect_pc, e.rpc);
        check({e.nm, ".count"}, {16'd0, mispredict_count}, {16'd0, e.cnt});
      end
    end
  end

  // ---------------- reference model ----------------
  // Entry keyed by index; the tag is simply the upper PC bits.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_cnt;

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_cnt = 0;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int idx = (pc / 4) % 16;
    return m_valid[idx] && (m_tag[idx] == pc / 64);
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit pt, output logic [31:0] tg);
    int idx = (pc / 4) % 16;
    pt = m_hit(pc) && (m_ctr[idx] >= 2);
    tg = pt ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic bit m_outcome(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    case (f3)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa <  sb;
      3'd5: return sa >= sb;
      3'd6: return ua <  ub;
      3'd7: return ua >= ub;
      default: return 0;
    endcase
  endfunction

  // Drive one cycle, queue its expectation, advance the model across the edge.
  task automatic step(input string nm, input bit v, input bit br, input bit jal,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input bit ept, input logic [31:0] eptgt, input bit st,
                      input logic [31:0] ifpc);
    exp_t e;
    bit   active, taken, mis, pt;
    logic [31:0] ptg;
    int   idx;
    if_pc = ifpc; ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_funct3 = f3;
    ex_rs1_data = a; ex_rs2_data = b; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = ept; ex_pred_target = eptgt; stall = st;

    m_lookup(ifpc, pt, ptg);
    active = v && (br || jal) && !st;
    taken  = jal || (br && m_outcome(f3, a, b));
    mis    = active && (taken ? (!ept || eptgt != tgt) : ept);
    e.nm = nm; e.pt = pt; e.ptgt = ptg; e.rd = mis;
    e.rpc = taken ? tgt : pc + 32'd4;
    e.cnt = 16'(m_cnt);
    q.push_back(e);

    if (active) begin
      idx = (pc / 4) % 16;
      if (jal || (!m_hit(pc) && taken)) begin
        m_valid[idx] = 1; m_tag[idx] = pc / 64; m_tgt[idx] = tgt;
        m_ctr[idx] = jal ? 3 : 2;
      end else if (m_hit(pc)) begin
        if (taken) begin
          m_tgt[idx] = tgt;
          m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        end else begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
      end
    end
    if (mis && m_cnt < 65535) m_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm, input logic [31:0] ifpc);
    step(nm, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, ifpc);
  endtask

  // Reset asserted between edges; expectation covers the reset window.
  task automatic mid_reset(input logic [31:0] ifpc);
    exp_t e;
    if_pc = ifpc; ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; stall = 0;
    reset = 1'b1;
    m_clear();
    e.nm = "reset"; e.pt = 0; e.ptgt = ifpc + 32'd4; e.rd = 0; e.rpc = 0; e.cnt = 0;
    q.push_back(e);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          pt;
    logic [31:0] ptg, pc, ifp;
    int          wait_cyc;

    reset = 1'b1; if_pc = 0; ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0;
    ex_funct3 = 0; ex_rs1_data = 0; ex_rs2_data = 0; ex_pc = 0; ex_target = 0;
    ex_pred_taken = 0; ex_pred_target = 0; stall = 0;
    m_clear();
    @(posedge clk); #1;
    mid_reset(32'h100);
    idle("reset_state", 32'h100);

    // Cold BNE, then lookup hit
    step("cold_bne", 1, 1, 0, 3'b001, 1, 2, 32'h100, 32'h140, 0, 0, 0, 32'h0);
    idle("bne_lookup", 32'h100);

    // Counter up to saturation, then down twice
    for (int i = 0; i < 3; i++)
      step("bne_sat_up", 1, 1, 0, 3'b001, 1, 2, 32'h100, 32'h140, 1, 32'h140, 0, 32'h100);
    for (int i = 0; i < 2; i++)
      step("bne_down", 1, 1, 0, 3'b001, 7, 7, 32'h100, 32'h140, 1, 32'h140, 0, 32'h100);
    idle("bne_ctr01", 32'h100);

    // Signed vs unsigned compares
    step("blt",  1, 1, 0, 3'b100, 32'hFFFFFFFF, 1, 32'h300, 32'h380, 0, 0, 0, 32'h300);
    step("bltu", 1, 1, 0, 3'b110, 32'hFFFFFFFF, 1, 32'h304, 32'h384, 1, 32'h384, 0, 32'h304);
    step("bgeu", 1, 1, 0, 3'b111, 32'hFFFFFFFF, 1, 32'h308, 32'h388, 0, 0, 0, 32'h308);
    step("bge",  1, 1, 0, 3'b101, 32'hFFFFFFFF, 1, 32'h30C, 32'h38C, 1, 32'h38C, 0, 32'h30C);

    // Predicted taken, actually not taken; then stalled on same inputs
    step("beq_nt",    1, 1, 0, 3'b000, 5, 6, 32'h200, 32'h280, 1, 32'h280, 0, 32'h200);
    step("beq_stall", 1, 1, 0, 3'b000, 5, 6, 32'h200, 32'h280, 1, 32'h280, 1, 32'h200);
    idle("beq_nochg", 32'h200);

    // Aliasing: JAL at 0x1100 evicts 0x100
    step("jal_alias", 1, 0, 1, 3'b000, 0, 0, 32'h1100, 32'h1800, 0, 0, 0, 32'h100);
    idle("alias_miss", 32'h100);
    idle("alias_hit", 32'h1100);

    // Pc+4 wrap on not-taken mispredict
    step("wrap", 1, 1, 0, 3'b010, 0, 0, 32'hFFFFFFFC, 32'h10, 1, 32'h10, 0, 32'h0);

    // Reset mid-operation after training four entries
    for (int i = 0; i < 4; i++)
      step("train4", 1, 0, 1, 3'b000, 0, 0, 32'h400 + 4*i, 32'h900 + 16*i, 0, 0, 0, 32'h400);
    idle("trained", 32'h404);
    mid_reset(32'h400);
    for (int i = 0; i < 4; i++) idle("post_reset", 32'h400 + 4*i);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      pc  = 32'h800 + 4*$urandom_range(0, 23) + 32'h1000*$urandom_range(0, 1);
      ifp = 32'h800 + 4*$urandom_range(0, 23) + 32'h1000*$urandom_range(0, 1);
      m_lookup(pc, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin pt = 1'($urandom); ptg = $urandom; end
      step("rand", ($urandom_range(0, 7) != 0), 1'($urandom), ($urandom_range(0, 5) == 0),
           3'($urandom), ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 3)),
           ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 3)),
           pc, pc + 4*$urandom_range(1, 4), pt, ptg, ($urandom_range(0, 5) == 0), ifp);
    end

    // Mispredict counter saturation
    for (int i = 0; i < 65540; i++)
      step("cnt_sat", 1, 0, 1, 3'b000, 0, 0, 32'h600, 32'h700, 0, 0, 0, 32'h0);
    idle("cnt_ffff", 32'h0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk); wait_cyc++;
    end
    if (q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
